output_sig_collector: RTL and testbench

Downstream consumer of the 28-bit combinational datapath result word. It registers each word through a valid/ready handshake into a small FIFO. It folds consecutive words into a 32-bit rotate-XOR signature and emits one signature per block of BLOCK_LEN words, or per flush, over a second valid/ready handshake. This gives the regression bench a compact, backpressure-tolerant checksum of the datapath output stream.

---
 rtl/output_sig_collector.sv | 78 +++++++
 tb/tb_output_sig_collector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/output_sig_collector.sv
// output_sig_collector: FIFO-buffered rotate-XOR signature of the datapath result stream
module output_sig_collector #(
  parameter int DATA_W    = 28,
  parameter int SIG_W     = 32,
  parameter int DEPTH     = 4,
  parameter int BLOCK_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       sig_valid,
  input  logic                       sig_ready,
  output logic [SIG_W-1:0]           sig_data,
  output logic [7:0]                 sig_words,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [0:0]        state_q, state_d;
  logic [SIG_W-1:0]  acc_q, acc_d, fold, sig_data_q, sig_data_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc, sig_words_q, sig_words_d;
  logic              push, pop, close, release_sig;
  assign in_ready   = !rst && (level_q != LW'(DEPTH));
  assign sig_valid  = (state_q == EMIT);
  assign sig_data   = sig_data_q;
  assign sig_words  = sig_words_q;
  assign fifo_level = level_q;
  // Pop/fold while accumulating, close a block on count or flush, reopen on handshake
  always_comb begin
    push        = in_valid && in_ready;
    pop         = (state_q == ACCUM) && (level_q != '0);
    release_sig = (state_q == EMIT) && sig_ready;
    fold        = {acc_q[SIG_W-2:0], acc_q[SIG_W-1]} ^ SIG_W'(mem_q[rd_ptr_q]);
    cnt_inc     = cnt_q + 8'd1;
    close       = (state_q == ACCUM) &&
                  ((pop && cnt_inc == 8'(BLOCK_LEN)) || (flush && (cnt_q != '0 || pop)));
    acc_d       = release_sig ? '0 : pop ? fold : acc_q;
    cnt_d       = release_sig ? '0 : pop ? cnt_inc : cnt_q;
    state_d     = close ? EMIT : release_sig ? ACCUM : state_q;
    sig_data_d  = close ? acc_d : sig_data_q;
    sig_words_d = close ? cnt_d : sig_words_q;
    level_d     = level_q + LW'(push) - LW'(pop);
  end
  // FIFO storage needs no reset; occupancy tracking makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
  // Pointers, occupancy, accumulator and signature registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sig_data_q  <= '0;
      sig_words_q <= '0;
    end else begin
      wr_ptr_q    <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q    <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_q     <= level_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sig_data_q  <= sig_data_d;
      sig_words_q <= sig_words_d;
    end
  end
endmodule

// File: tb/tb_output_sig_collector.sv
// tb_output_sig_collector: three block lengths driven in parallel against a queue-based model
module tb_output_sig_collector;
  localparam int NI    = 3;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, sig_ready = 1'b0;
  logic [27:0] in_data = '0;
  logic [NI-1:0]       ir_w, sv_w;
  logic [NI-1:0][31:0] sd_w;
  logic [NI-1:0][7:0]  sw_w;
  logic [NI-1:0][2:0]  lv_w;
  int          bl_m [NI] = '{1, 2, 8};
  logic [27:0] mq [NI][$];
  logic [31:0] capq [NI][$];
  logic [31:0] m_acc [NI], m_sd [NI];
  logic [7:0]  m_sw [NI];
  int          m_cnt [NI];
  bit          m_emit [NI], m_hs [NI];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    output_sig_collector #(.BLOCK_LEN(g == 0 ? 1 : g == 1 ? 2 : 8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[g]), .in_data(in_data),
      .flush(flush), .sig_valid(sv_w[g]), .sig_ready(sig_ready), .sig_data(sd_w[g]),
      .sig_words(sw_w[g]), .fifo_level(lv_w[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      m_acc[i] = 0; m_sd[i] = 0; m_sw[i] = 0; m_cnt[i] = 0; m_emit[i] = 0; m_hs[i] = 0;
    end
  endtask
  task automatic close_block(input int i);
    m_emit[i] = 1; m_sd[i] = m_acc[i]; m_sw[i] = 8'(m_cnt[i]);
  endtask
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      bit take;
      take = in_valid && !rst && mq[i].size() != DEPTH;
      if (rst) begin
        mq[i].delete();
        m_acc[i] = 0; m_sd[i] = 0; m_sw[i] = 0; m_cnt[i] = 0; m_emit[i] = 0; m_hs[i] = 0;
      end else begin
        if (m_emit[i]) begin
          if (sig_ready) begin m_emit[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_hs[i] = 1; end
        end else if (mq[i].size() != 0) begin
          m_acc[i] = ((m_acc[i] << 1) | (m_acc[i] >> 31)) ^ {4'h0, mq[i].pop_front()};
          m_cnt[i]++;
          if (m_cnt[i] == bl_m[i] || flush) close_block(i);
        end else if (flush && m_cnt[i] != 0) close_block(i);
        if (take) mq[i].push_back(in_data);
      end
    end
  endtask
  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      if (m_hs[i]) begin capq[i].push_back(sd_w[i]); m_hs[i] = 0; end
      chk($sformatf("u%0d_ready", i), 32'(ir_w[i]), 32'(!rst && mq[i].size() != DEPTH));
      chk($sformatf("u%0d_level", i), 32'(lv_w[i]), 32'(mq[i].size()));
      chk($sformatf("u%0d_valid", i), 32'(sv_w[i]), 32'(m_emit[i]));
      chk($sformatf("u%0d_sig", i), sd_w[i], m_sd[i]);
      chk($sformatf("u%0d_words", i), 32'(sw_w[i]), 32'(m_sw[i]));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic push(input logic [27:0] d);
    in_valid = 1; in_data = d; tick(); in_valid = 0;
  endtask
  task automatic idle(input int n);
    in_valid = 0; flush = 0;
    repeat (n) tick();
  endtask
  task automatic drain();
    sig_ready = 1; flush = 1; tick(); flush = 0; idle(4);
    flush = 1; tick(); flush = 0; idle(4);
    for (int i = 0; i < NI; i++) capq[i].delete();
  endtask
  initial begin
    int k, guard;
    model_clear();
    @(negedge clk);
    repeat (2) tick();
    rst = 0; sig_ready = 1;
    tick();
    push(28'h3); push(28'h5); idle(4);
    chk("p1_count", 32'(capq[1].size()), 32'd1);
    if (capq[1].size() > 0) chk("p1_sig", capq[1][0], 32'h3);
    drain();
    repeat (3) push(28'hFFFFFFF);
    idle(4);
    flush = 1; tick(); flush = 0; idle(3);
    chk("p2_count", 32'(capq[2].size()), 32'd1);
    if (capq[2].size() > 0) chk("p2_sig", capq[2][0], 32'h2FFFFFFD);
    flush = 1; tick(); flush = 0;
    chk("p2_idle_flush", 32'(sv_w[2]), 32'd0);
    idle(2);
    drain();
    sig_ready = 0;
    for (int j = 0; j < 7; j++) begin in_valid = 1; in_data = 28'(j + 'h10); tick(); end
    chk("p3_level", 32'(lv_w[1]), 32'd4);
    chk("p3_stall", 32'(ir_w[1]), 32'd0);
    sig_ready = 1; tick(); tick();
    in_valid = 0; idle(15);
    chk("p3_sigs", 32'(capq[1].size()), 32'd3);
    drain();
    k = 1; guard = 0;
    while (k <= 20 && guard < 400) begin
      bit acc;
      in_valid = 1'($urandom % 2); in_data = 28'(k);
      acc = in_valid && mq[0].size() != DEPTH;
      tick();
      if (acc) k++;
      guard++;
    end
    in_valid = 0; idle(10);
    chk("p4_fed", 32'(k), 32'd21);
    chk("p4_count", 32'(capq[0].size()), 32'd20);
    for (int j = 0; j < capq[0].size() && j < 20; j++) chk($sformatf("p4_sig%0d", j), capq[0][j], 32'(j + 1));
    drain();
    push(28'h1); push(28'h2); push(28'h8);
    flush = 1; tick(); flush = 0; idle(3);
    chk("p5_count", 32'(capq[2].size()), 32'd1);
    if (capq[2].size() > 0) chk("p5_sig", capq[2][0], 32'h8);
    drain();
    sig_ready = 0;
    for (int j = 0; j < 5; j++) push(28'(j + 'h40));
    chk("p6_emit", 32'(sv_w[1]), 32'd1);
    chk("p6_level", 32'(lv_w[1]), 32'd3);
    #2 rst = 1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("p6_rst_ready%0d", i), 32'(ir_w[i]), 32'd0);
      chk($sformatf("p6_rst_level%0d", i), 32'(lv_w[i]), 32'd0);
      chk($sformatf("p6_rst_valid%0d", i), 32'(sv_w[i]), 32'd0);
    end
    model_clear();
    tick();
    #2 rst = 0;
    sig_ready = 1;
    for (int i = 0; i < NI; i++) capq[i].delete();
    push(28'h3); push(28'h5); idle(4);
    chk("p6_count", 32'(capq[1].size()), 32'd1);
    if (capq[1].size() > 0) chk("p6_sig", capq[1][0], 32'h3);
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = 1'($urandom % 2);
      in_data = 28'($urandom);
      flush = ($urandom % 8 == 0);
      sig_ready = ($urandom % 3 != 0);
      tick();
    end
    rst = 0;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
